// File: rtl/cam_pkg.sv
// ============================================================================
//  Module      : cam_pkg
//  Description : Shared types and defaults for the camera line scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_pkg;

  localparam int unsigned c_LINE_WORDS_DEF  = 960;
  localparam int unsigned c_FRAME_LINES_DEF = 240;
  localparam int unsigned c_LINE_CNT_W_DEF  = 10;

  localparam int unsigned c_PIX_W      = 16;
  localparam int unsigned c_PIX_ADDR_W = 10;
  localparam int unsigned c_BUF_ADDR_W = c_PIX_ADDR_W + 1;
  localparam int unsigned c_DROP_W     = 8;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_ARMED     = 5'b00010,
    ST_LINE_WAIT = 5'b00100,
    ST_LINE_WR   = 5'b01000,
    ST_LINE_DROP = 5'b10000
  } state_t;

  function automatic logic [c_DROP_W-1:0] sat_inc(input logic [c_DROP_W-1:0] v);
    return (&v) ? v : v + c_DROP_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cam_line_scheduler_if.sv
// ============================================================================
//  Module      : cam_line_scheduler_if
//  Description : Receiver, buffer-RAM and consumer signals of the scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cam_line_scheduler_if
  import cam_pkg::*;
#(
  parameter int unsigned LINE_CNT_W = c_LINE_CNT_W_DEF
);
  logic                    VSYNC;
  logic                    HSYNC;
  logic                    PCLK;
  logic                    LINE_END;
  logic [c_PIX_W-1:0]      PIX_DATA;
  logic [c_PIX_ADDR_W-1:0] PIX_ADDR;
  logic                    CAP_EN;
  logic                    CAP_SINGLE;
  logic                    CAP_START;
  logic                    BUF_WE;
  logic [c_BUF_ADDR_W-1:0] BUF_ADDR;
  logic [c_PIX_W-1:0]      BUF_DATA;
  logic                    LINE_VALID;
  logic                    LINE_BANK;
  logic [LINE_CNT_W-1:0]   LINE_NUM;
  logic                    LINE_ACK;
  logic                    FRAME_START;
  logic                    FRAME_DONE;
  logic                    BUSY;
  logic [c_DROP_W-1:0]     DROP_CNT;

  modport master (
    output VSYNC, HSYNC, PCLK, LINE_END, PIX_DATA, PIX_ADDR,
           CAP_EN, CAP_SINGLE, CAP_START, LINE_ACK,
    input  BUF_WE, BUF_ADDR, BUF_DATA, LINE_VALID, LINE_BANK, LINE_NUM,
           FRAME_START, FRAME_DONE, BUSY, DROP_CNT
  );

  modport slave (
    input  VSYNC, HSYNC, PCLK, LINE_END, PIX_DATA, PIX_ADDR,
           CAP_EN, CAP_SINGLE, CAP_START, LINE_ACK,
    output BUF_WE, BUF_ADDR, BUF_DATA, LINE_VALID, LINE_BANK, LINE_NUM,
           FRAME_START, FRAME_DONE, BUSY, DROP_CNT
  );

endinterface

`default_nettype wire

// File: rtl/cam_bank_tracker.sv
// ============================================================================
//  Module      : cam_bank_tracker
//  Description : Full/oldest bookkeeping and free-bank choice for the
//                two-bank line buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_bank_tracker
  import cam_pkg::*;
#(
  parameter int unsigned LINE_CNT_W = c_LINE_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_mark,
  input  logic                  i_mark_bank,
  input  logic [LINE_CNT_W-1:0] i_mark_tag,
  input  logic                  i_release,
  output logic                  o_valid,
  output logic                  o_bank,
  output logic [LINE_CNT_W-1:0] o_tag,
  output logic                  o_free_any,
  output logic                  o_free_bank
);

  logic [1:0]                 r_full;
  logic                       r_oldest;
  logic                       r_last;
  logic [1:0][LINE_CNT_W-1:0] r_tag;

  logic       w_rel;
  logic [1:0] w_full_rel;
  logic [1:0] w_full_n;
  logic       w_oldest_n;

  assign w_rel = i_release & (|r_full);

  // A release drops the oldest entry first, so a simultaneous mark is judged
  // against what remains.
  always_comb begin
    w_full_rel = r_full;
    if (w_rel) w_full_rel[r_oldest] = 1'b0;
    w_full_n = w_full_rel;
    if (i_mark) w_full_n[i_mark_bank] = 1'b1;
    w_oldest_n = r_oldest;
    if (i_mark && (w_full_rel == 2'b00)) w_oldest_n = i_mark_bank;
    else if (w_rel)                      w_oldest_n = ~r_oldest;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full   <= 2'b00;
      r_oldest <= 1'b0;
      r_last   <= 1'b1;
      r_tag    <= '0;
    end else begin
      r_full   <= w_full_n;
      r_oldest <= w_oldest_n;
      if (i_mark) begin
        r_last              <= i_mark_bank;
        r_tag[i_mark_bank]  <= i_mark_tag;
      end
    end
  end

  assign o_valid     = |r_full;
  assign o_bank      = r_oldest;
  assign o_tag       = r_tag[r_oldest];
  assign o_free_any  = ~&r_full;
  assign o_free_bank = (r_full == 2'b00) ? ~r_last : r_full[0];

endmodule

`default_nettype wire

// File: rtl/cam_line_scheduler.sv
// ============================================================================
//  Module      : cam_line_scheduler
//  Description : Sequences camera lines into a ping-pong line buffer and
//                hands completed lines to a consumer. Optional vertical
//                decimation by 2 via CAM_LINE_DECIM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_line_scheduler
  import cam_pkg::*;
#(
  parameter int unsigned LINE_WORDS  = c_LINE_WORDS_DEF,
  parameter int unsigned FRAME_LINES = c_FRAME_LINES_DEF,
  parameter int unsigned LINE_CNT_W  = c_LINE_CNT_W_DEF
) (
  input  logic                CAM_CLK,
  input  logic                RESETn,
  cam_line_scheduler_if.slave bus
);

  state_t r_state, w_state_n;

  logic r_vs, r_vs_d, r_hs, r_hs_d, r_le, r_le_d, r_pclk_d;
  logic w_vs_rise, w_hs_rise, w_le_rise;

  logic [LINE_CNT_W-1:0]   r_line_cnt;
  logic                    r_wr_bank;
  logic [c_DROP_W-1:0]     r_drop_cnt;
  logic                    r_frame_start, r_frame_done;
  logic                    r_buf_we;
  logic [c_BUF_ADDR_W-1:0] r_buf_addr;
  logic [c_PIX_W-1:0]      r_buf_data;

  logic w_frame_start, w_frame_done, w_line_clr, w_line_inc;
  logic w_mark, w_drop_inc, w_wr_load, w_wr_strobe;
  logic w_last_line, w_decim_skip;
  logic w_valid, w_bank, w_free_any, w_free_bank;
  logic [LINE_CNT_W-1:0] w_tag;

`ifdef CAM_LINE_DECIM_EN
  assign w_decim_skip = r_line_cnt[0];
`else
  assign w_decim_skip = 1'b0;
`endif

  assign w_vs_rise   = r_vs & ~r_vs_d;
  assign w_hs_rise   = r_hs & ~r_hs_d;
  assign w_le_rise   = r_le & ~r_le_d;
  assign w_last_line = (r_line_cnt == LINE_CNT_W'(FRAME_LINES - 1));
  assign w_wr_strobe = (r_state == ST_LINE_WR) & r_pclk_d &
                       (32'(bus.PIX_ADDR) < LINE_WORDS);

  always_ff @(posedge CAM_CLK or negedge RESETn) begin
    if (!RESETn) begin
      {r_vs, r_vs_d, r_hs, r_hs_d, r_le, r_le_d, r_pclk_d} <= '0;
    end else begin
      r_vs     <= bus.VSYNC;
      r_vs_d   <= r_vs;
      r_hs     <= bus.HSYNC;
      r_hs_d   <= r_hs;
      r_le     <= bus.LINE_END;
      r_le_d   <= r_le;
      r_pclk_d <= bus.PCLK;
    end
  end

  always_ff @(posedge CAM_CLK or negedge RESETn) begin
    if (!RESETn) r_state <= ST_IDLE;
    else         r_state <= w_state_n;
  end

  // CAP_EN low overrides everything; VSYNC restarts the frame from any
  // active state, abandoning the partial line.
  always_comb begin
    w_state_n     = r_state;
    w_frame_start = 1'b0;
    w_frame_done  = 1'b0;
    w_line_clr    = 1'b0;
    w_line_inc    = 1'b0;
    w_mark        = 1'b0;
    w_drop_inc    = 1'b0;
    w_wr_load     = 1'b0;
    if (!bus.CAP_EN) begin
      w_state_n = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.CAP_START) w_state_n = ST_ARMED;
        end
        ST_ARMED, ST_LINE_WAIT, ST_LINE_WR, ST_LINE_DROP: begin
          if (w_vs_rise) begin
            w_state_n     = ST_LINE_WAIT;
            w_line_clr    = 1'b1;
            w_frame_start = 1'b1;
          end else if (r_state == ST_LINE_WAIT) begin
            if (w_hs_rise) begin
              if (w_decim_skip) begin
                w_state_n = ST_LINE_DROP;
              end else if (w_free_any) begin
                w_state_n = ST_LINE_WR;
                w_wr_load = 1'b1;
              end else begin
                w_state_n  = ST_LINE_DROP;
                w_drop_inc = 1'b1;
              end
            end
          end else if ((r_state != ST_ARMED) && w_le_rise) begin
            w_line_inc = 1'b1;
            w_mark     = (r_state == ST_LINE_WR);
            if (w_last_line) begin
              w_frame_done = 1'b1;
              w_state_n    = bus.CAP_SINGLE ? ST_IDLE : ST_ARMED;
            end else begin
              w_state_n = ST_LINE_WAIT;
            end
          end
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CAM_CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_line_cnt    <= '0;
      r_wr_bank     <= 1'b0;
      r_drop_cnt    <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_buf_we      <= 1'b0;
      r_buf_addr    <= '0;
      r_buf_data    <= '0;
    end else begin
      r_frame_start <= w_frame_start;
      r_frame_done  <= w_frame_done;
      if (w_line_clr)      r_line_cnt <= '0;
      else if (w_line_inc) r_line_cnt <= r_line_cnt + LINE_CNT_W'(1);
      if (w_wr_load)  r_wr_bank  <= w_free_bank;
      if (w_drop_inc) r_drop_cnt <= sat_inc(r_drop_cnt);
      r_buf_we <= w_wr_strobe;
      if (w_wr_strobe) begin
        r_buf_addr <= {r_wr_bank, bus.PIX_ADDR};
        r_buf_data <= bus.PIX_DATA;
      end
    end
  end

  cam_bank_tracker #(
    .LINE_CNT_W (LINE_CNT_W)
  ) u_banks (
    .clk         (CAM_CLK),
    .rst_n       (RESETn),
    .i_mark      (w_mark),
    .i_mark_bank (r_wr_bank),
    .i_mark_tag  (r_line_cnt),
    .i_release   (bus.LINE_ACK),
    .o_valid     (w_valid),
    .o_bank      (w_bank),
    .o_tag       (w_tag),
    .o_free_any  (w_free_any),
    .o_free_bank (w_free_bank)
  );

  assign bus.BUF_WE      = r_buf_we;
  assign bus.BUF_ADDR    = r_buf_addr;
  assign bus.BUF_DATA    = r_buf_data;
  assign bus.LINE_VALID  = w_valid;
  assign bus.LINE_BANK   = w_bank;
  assign bus.LINE_NUM    = w_tag;
  assign bus.FRAME_START = r_frame_start;
  assign bus.FRAME_DONE  = r_frame_done;
  assign bus.BUSY        = (r_state != ST_IDLE);
  assign bus.DROP_CNT    = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cam_line_scheduler.sv
// ============================================================================
//  Module      : tb_cam_line_scheduler
//  Description : Directed and randomized bench for cam_line_scheduler with a
//                queue-based reference model of the line buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cam_line_scheduler;

  localparam int LW  = 960;
  localparam int FL  = 4;
  localparam int LCW = 10;
`ifdef CAM_LINE_DECIM_EN
  localparam bit DECIM = 1'b1;
`else
  localparam bit DECIM = 1'b0;
`endif

  localparam int M_IDLE = 0, M_ARMED = 1, M_WAIT = 2, M_WR = 3, M_DROP = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  cam_line_scheduler_if #(.LINE_CNT_W(LCW)) bus ();

  cam_line_scheduler #(
    .LINE_WORDS  (LW),
    .FRAME_LINES (FL),
    .LINE_CNT_W  (LCW)
  ) dut (
    .CAM_CLK (clk),
    .RESETn  (rstn),
    .bus     (bus)
  );

  typedef struct { int bank; int num; } ent_t;

  // Reference model: full banks kept as an oldest-first queue.
  ent_t m_q[$];
  int   m_mode, m_line, m_wr_bank, m_last, m_drop;
  bit   m_vs1, m_vs2, m_hs1, m_hs2, m_le1, m_le2, m_pclk1;
  bit   e_we, e_fs, e_fd;
  int   e_addr, e_data;

  int n_vec = 0, n_err = 0, n_we = 0;
  bit r_rand_ack = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode = M_IDLE; m_line = 0; m_wr_bank = 0; m_last = 1; m_drop = 0;
    {m_vs1, m_vs2, m_hs1, m_hs2, m_le1, m_le2, m_pclk1} = '0;
    e_we = 0; e_fs = 0; e_fd = 0; e_addr = 0; e_data = 0;
  endtask

  function automatic bit bank_full(int b);
    foreach (m_q[i]) if (m_q[i].bank == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit vs, hs, le, ack, f0, f1, push;
    ent_t ent;
    if (!rstn) begin model_reset(); return; end
    vs = m_vs1 && !m_vs2;
    hs = m_hs1 && !m_hs2;
    le = m_le1 && !m_le2;
    e_we = (m_mode == M_WR) && m_pclk1 && (int'(bus.PIX_ADDR) < LW);
    if (e_we) begin
      e_addr = m_wr_bank * 1024 + int'(bus.PIX_ADDR);
      e_data = int'(bus.PIX_DATA);
    end
    e_fs = 0; e_fd = 0; push = 0;
    f0 = !bank_full(0);
    f1 = !bank_full(1);
    ack = bus.LINE_ACK && (m_q.size() > 0);
    if (!bus.CAP_EN) m_mode = M_IDLE;
    else if (m_mode == M_IDLE) begin
      if (bus.CAP_START) m_mode = M_ARMED;
    end else if (vs) begin
      m_mode = M_WAIT; m_line = 0; e_fs = 1;
    end else if (m_mode == M_WAIT && hs) begin
      if (DECIM && (m_line % 2 == 1)) m_mode = M_DROP;
      else if (f0 || f1) begin
        m_wr_bank = (f0 && f1) ? 1 - m_last : (f0 ? 0 : 1);
        m_mode = M_WR;
      end else begin
        m_mode = M_DROP;
        if (m_drop < 255) m_drop++;
      end
    end else if ((m_mode == M_WR || m_mode == M_DROP) && le) begin
      if (m_mode == M_WR) begin
        ent.bank = m_wr_bank; ent.num = m_line; push = 1; m_last = m_wr_bank;
      end
      if (m_line == FL - 1) begin
        e_fd = 1;
        m_mode = bus.CAP_SINGLE ? M_IDLE : M_ARMED;
      end else m_mode = M_WAIT;
      m_line = (m_line + 1) % (1 << LCW);
    end
    if (ack) void'(m_q.pop_front());
    if (push) m_q.push_back(ent);
    m_vs2 = m_vs1; m_vs1 = bus.VSYNC;
    m_hs2 = m_hs1; m_hs1 = bus.HSYNC;
    m_le2 = m_le1; m_le1 = bus.LINE_END;
    m_pclk1 = bus.PCLK;
  endtask

  task automatic check_outputs();
    chk("buf_we", bus.BUF_WE, e_we);
    if (e_we) begin
      n_we++;
      chk("buf_addr", bus.BUF_ADDR, e_addr);
      chk("buf_data", bus.BUF_DATA, e_data);
    end
    chk("line_valid", bus.LINE_VALID, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("line_bank", bus.LINE_BANK, m_q[0].bank);
      chk("line_num", bus.LINE_NUM, m_q[0].num);
    end
    chk("frame_start", bus.FRAME_START, e_fs);
    chk("frame_done", bus.FRAME_DONE, e_fd);
    chk("busy", bus.BUSY, m_mode != M_IDLE);
    chk("drop_cnt", bus.DROP_CNT, m_drop);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    if (r_rand_ack) bus.LINE_ACK = ($urandom_range(0, 3) == 0);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_vsync();
    bus.VSYNC = 1; run(2); bus.VSYNC = 0; run(1);
  endtask

  task automatic line_start();
    bus.HSYNC = 1; run(2); bus.HSYNC = 0; run(1);
  endtask

  // Each word: strobe for one cycle, address/data held through the next.
  task automatic words(input int n, input int a0);
    for (int i = 0; i < n; i++) begin
      bus.PIX_ADDR = 10'(a0 + i);
      bus.PIX_DATA = 16'($urandom);
      bus.PCLK = 1; cycle();
      bus.PCLK = 0; cycle();
    end
  endtask

  task automatic line_end(input bit ack_same);
    bus.LINE_END = 1; cycle();
    if (ack_same) bus.LINE_ACK = 1;
    cycle();
    bus.LINE_ACK = 0; bus.LINE_END = 0; cycle();
  endtask

  task automatic ack_line();
    bus.LINE_ACK = 1; cycle(); bus.LINE_ACK = 0; cycle();
  endtask

  task automatic full_line(input int n, input int a0, input bit ack_after);
    line_start(); words(n, a0); line_end(1'b0);
    if (ack_after) ack_line();
  endtask

  initial begin
    int we0;
    rstn = 0;
    {bus.VSYNC, bus.HSYNC, bus.PCLK, bus.LINE_END} = '0;
    bus.PIX_DATA = '0; bus.PIX_ADDR = '0;
    {bus.CAP_EN, bus.CAP_SINGLE, bus.CAP_START, bus.LINE_ACK} = '0;
    model_reset();
    run(3);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_valid", bus.LINE_VALID, 0);
    chk("rst_drop", bus.DROP_CNT, 0);
    rstn = 1;
    run(2);

    // Three lines, no consumer: third line has no bank.
    bus.CAP_EN = 1; bus.CAP_START = 1; cycle(); bus.CAP_START = 0; cycle();
    pulse_vsync();
    for (int l = 0; l < 3; l++) full_line(LW, 0, 1'b0);
`ifndef CAM_LINE_DECIM_EN
    chk("t1_drop", bus.DROP_CNT, 1);
    chk("t1_valid", bus.LINE_VALID, 1);
    chk("t1_bank", bus.LINE_BANK, 0);
    chk("t1_num", bus.LINE_NUM, 0);
`endif
    ack_line(); ack_line();

    // Consumer keeps up: banks alternate 0,1,0.
    pulse_vsync();
    for (int l = 0; l < 3; l++) begin
      full_line(LW, 0, 1'b0);
`ifndef CAM_LINE_DECIM_EN
      chk("t2_bank", bus.LINE_BANK, l % 2);
`endif
      ack_line();
    end
`ifndef CAM_LINE_DECIM_EN
    chk("t2_drop", bus.DROP_CNT, 1);
`else
    chk("t2_drop", bus.DROP_CNT, 0);
`endif

    // Single-shot frame of FL lines, then a line that must not be written.
    bus.CAP_SINGLE = 1;
    pulse_vsync();
    for (int l = 0; l < FL; l++) full_line(16, 0, 1'b1);
    chk("t3_busy", bus.BUSY, 0);
    we0 = n_we;
    full_line(16, 0, 1'b0);
    chk("t3_nowr", n_we - we0, 0);

    // VSYNC mid-line aborts; the next line reuses the same bank.
    bus.CAP_SINGLE = 0; bus.CAP_START = 1; cycle(); bus.CAP_START = 0; cycle();
    pulse_vsync();
    line_start(); words(500, 0); pulse_vsync();
    chk("t4_valid", bus.LINE_VALID, 0);
    full_line(8, 0, 1'b0);
`ifndef CAM_LINE_DECIM_EN
    chk("t4_bank", bus.LINE_BANK, 1);
    chk("t4_num", bus.LINE_NUM, 0);

    // Line completion and ACK in the same cycle.
    line_start(); words(8, 100); line_end(1'b1);
    chk("t5_valid", bus.LINE_VALID, 1);
    chk("t5_bank", bus.LINE_BANK, 0);
    chk("t5_num", bus.LINE_NUM, 1);
`endif

    // Randomized traffic including out-of-range addresses.
    r_rand_ack = 1;
    bus.CAP_START = 1; cycle(); bus.CAP_START = 0; cycle();
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 9))
        0: pulse_vsync();
        1: begin bus.CAP_EN = 0; run(2); bus.CAP_EN = 1; run(1); end
        2: begin
          bus.CAP_SINGLE = 1'($urandom_range(0, 1));
          bus.CAP_START = 1; cycle(); bus.CAP_START = 0; cycle();
        end
        default: begin
          line_start();
          words($urandom_range(1, 10),
                ($urandom_range(0, 1) == 1) ? $urandom_range(0, 20) : $urandom_range(950, 1023));
          if ($urandom_range(0, 5) == 0) pulse_vsync();
          line_end(1'b0);
        end
      endcase
    end
    r_rand_ack = 0; bus.LINE_ACK = 0;

    // Reset in the middle of a line.
    bus.CAP_START = 1; cycle(); bus.CAP_START = 0; cycle();
    pulse_vsync();
    line_start(); words(3, 0);
    rstn = 0;
    run(2);
    chk("rst2_busy", bus.BUSY, 0);
    chk("rst2_we", bus.BUF_WE, 0);
    chk("rst2_valid", bus.LINE_VALID, 0);
    rstn = 1;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cam_line_scheduler.md
Name: cam_line_scheduler

Overview:
- Sequences the camera line stream from the MIPI receiver into a two-bank (ping-pong) line buffer RAM.
- Tracks frame and line position and issues per-line ready handshakes to a downstream consumer (display/DMA reader).
- Drops lines when no bank is free, and supports continuous or single-shot capture.
- Sits between the MIPI receiver outputs and a dual-port BRAM of 2*LINE_WORDS x 16.

Parameters:
- LINE_WORDS, 960, 16-bit words per line; writes with PIX_ADDR >= LINE_WORDS are suppressed.
- FRAME_LINES, 240, lines per frame; the line at index FRAME_LINES-1 ends the frame.
- LINE_CNT_W, 10, width of the line counter and LINE_NUM.

Ports:
- CAM_CLK  in  1  sole clock.
- RESETn  in  1  asynchronous, active-low reset.
- VSYNC  in  1  level; rising edge = frame start.
- HSYNC  in  1  level; rising edge = line start.
- PCLK  in  1  one-cycle word strobe from the receiver.
- LINE_END  in  1  level; rising edge = line complete.
- PIX_DATA  in  16  pixel word.
- PIX_ADDR  in  10  word address within the line.
- CAP_EN  in  1  capture enable.
- CAP_SINGLE  in  1  1 = stop after one frame.
- CAP_START  in  1  pulse; arms capture.
- BUF_WE  out  1  RAM write enable.
- BUF_ADDR  out  11  {bank, word addr}.
- BUF_DATA  out  16  RAM write data.
- LINE_VALID  out  1  a full bank awaits the consumer.
- LINE_BANK  out  1  oldest full bank.
- LINE_NUM  out  LINE_CNT_W  source line index of LINE_BANK.
- LINE_ACK  in  1  consumer releases LINE_BANK.
- FRAME_START  out  1  one-cycle pulse.
- FRAME_DONE  out  1  one-cycle pulse.
- BUSY  out  1  state != IDLE.
- DROP_CNT  out  8  saturating dropped-line count.

Behaviour:
- Reset:
  - State = IDLE.
  - All outputs 0; both banks free; line counter 0; DROP_CNT 0.
- Edges: VSYNC, HSYNC and LINE_END are registered once; a rising edge is detected as current & ~previous.
- Write path, LINE_WR state only:
  - pclk_d = PCLK delayed 1 cycle.
  - When pclk_d=1 and PIX_ADDR < LINE_WORDS, then on the next edge: BUF_WE=1, BUF_ADDR={wr_bank, PIX_ADDR}, BUF_DATA=PIX_DATA.
  - Total latency: 2 cycles from the PCLK strobe to BUF_WE high.
  - BUF_WE is 0 in every other state.
- States:
  - IDLE: CAP_EN & CAP_START -> ARMED.
  - ARMED: VSYNC rise -> LINE_WAIT; line counter cleared; FRAME_START pulses.
  - LINE_WAIT, on HSYNC rise:
    - If a free bank exists -> LINE_WR; wr_bank = free bank, preferring ~last_written when both are free.
    - Otherwise -> LINE_DROP; DROP_CNT +1, saturating at 255.
  - LINE_WR, on LINE_END rise:
    - Bank marked full, tagged with the line count, appended as newest; line count +1.
    - If line count was FRAME_LINES-1: FRAME_DONE pulses, then -> IDLE if CAP_SINGLE, else -> ARMED.
    - Otherwise -> LINE_WAIT.
  - LINE_DROP, on LINE_END rise: same line-count and frame-end logic as LINE_WR, but no bank is marked full.
- VSYNC rise in LINE_WAIT, LINE_WR or LINE_DROP:
  - The partial line is aborted; its bank stays free.
  - Line count reset to 0; FRAME_START pulses; -> LINE_WAIT.
- CAP_EN=0 in any state:
  - -> IDLE next cycle; any partial line is aborted.
  - Full banks are retained until acknowledged.
- Consumer handshake:
  - LINE_VALID = any bank full.
  - LINE_BANK and LINE_NUM = oldest full bank and its tag.
  - LINE_ACK while LINE_VALID=1 frees that bank on the next edge; LINE_ACK while LINE_VALID=0 is ignored.
  - A line completion and an ACK in the same cycle both take effect; a bank freed this cycle is not reusable until the next cycle.
  - The bank being written is never reported valid.
- Line counter wraps at 2^LINE_CNT_W; only reachable with a misconfigured FRAME_LINES.
- Reset asserted mid-line: all state cleared immediately; RAM contents are don't-care.

Optional Feature:
- CAM_LINE_DECIM_EN defined:
  - Lines with odd line count go to LINE_DROP on HSYNC rise without incrementing DROP_CNT.
  - Vertical decimation by 2; LINE_NUM still reports the source index (always even).
- Not defined: every line is eligible for capture.

Decomposition:
- Shared package cam_pkg:
  - State encodings (one-hot, 5 states).
  - Default LINE_WORDS, FRAME_LINES, LINE_CNT_W.
  - BUF_ADDR width constant.
- Sub-module cam_bank_tracker:
  - Two full flags, oldest pointer, two line-number tags, free-bank select.
  - Inputs: mark_full (bank, tag) and release.

Test Plan:
- CAP_EN=1, CAP_START, VSYNC rise, 3 lines of 960 PCLKs, no ACK -> lines 0 and 1 fill banks 0 and 1; line 2 dropped; DROP_CNT=1; LINE_VALID=1, LINE_BANK=0, LINE_NUM=0.
- Same, with ACK after each line -> no drops; banks alternate 0,1,0; BUF_WE is 2 cycles after each PCLK; BUF_ADDR 0..959 then 1024..1983.
- FRAME_LINES=4, CAP_SINGLE=1 -> FRAME_DONE after 4th LINE_END; BUSY=0; a 5th HSYNC produces no writes.
- VSYNC rise at PIX_ADDR=500 in LINE_WR -> bank not marked full; FRAME_START pulses; line count 0; next line reuses the same bank.
- LINE_END rise and LINE_ACK in the same cycle with one bank full -> old bank freed, new bank full, LINE_VALID stays 1, LINE_BANK switches.
- CAM_LINE_DECIM_EN build, 4 lines with ACKs -> only LINE_NUM 0 and 2 reported; DROP_CNT=0.
